i2c_wb_arbiter: RTL and testbench

I2C_WB_ARBITER -- requirements
Module: i2c_wb_arbiter

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_i2c_wb_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: arbiter state encoding and default timeout.
// The configuration sequencers use this package as well.
package i2c_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_GNT0 = 2'd1,
      ST_GNT1 = 2'd2
   } arb_state_t;

   localparam int TIMEOUT_DEF = 4096;
   localparam int TO_W_DEF    = 13;

   // One-hot owner code for a given arbiter state (bit 0 = m0, bit 1 = m1).
   function automatic logic [1:0] grant_onehot(input arb_state_t st);
      logic [1:0] oh;
      oh = 2'b00;
      case (st)
         ST_GNT0: oh = 2'b01;
         ST_GNT1: oh = 2'b10;
         default: oh = 2'b00;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/i2c_wb_arbiter.sv
// Two-requester Wishbone arbiter in front of the shared I2C master core.
// The grant is locked for as long as the owner holds cyc, so multi-access
// I2C transactions are never interleaved. A stuck slave is escaped with a
// timeout that aborts the owner, and that requester stays locked out until
// it drops cyc.
module i2c_wb_arbiter
   import i2c_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int TO_W    = TO_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] m0_adr,
   input  logic [7:0] m0_dat_o,
   input  logic       m0_we,
   input  logic       m0_stb,
   input  logic       m0_cyc,
   output logic [7:0] m0_dat_i,
   output logic       m0_ack,
   output logic       m0_err,
   input  logic [2:0] m1_adr,
   input  logic [7:0] m1_dat_o,
   input  logic       m1_we,
   input  logic       m1_stb,
   input  logic       m1_cyc,
   output logic [7:0] m1_dat_i,
   output logic       m1_ack,
   output logic       m1_err,
   output logic [2:0] s_adr,
   output logic [7:0] s_dat_o,
   output logic       s_we,
   output logic       s_stb,
   output logic       s_cyc,
   input  logic [7:0] s_dat_i,
   input  logic       s_ack,
   output logic [1:0] owner
);

   localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

   arb_state_t      r_state;
   logic [1:0]      r_owner;
   logic            r_last;     // 1: m1 was granted last, 0: m0 was
   logic [TO_W-1:0] r_to_cnt;
   logic [1:0]      r_lock;

   logic w_own0;
   logic w_own1;
   logic w_own_cyc;
   logic w_own_stb;
   logic w_timeout;
   logic w_release;
   logic w_req0;
   logic w_req1;

   assign w_own0 = (r_state == ST_GNT0);
   assign w_own1 = (r_state == ST_GNT1);

   // A requester is eligible only while it is not serving a timeout lockout.
   assign w_req0 = m0_cyc & ~r_lock[0];
   assign w_req1 = m1_cyc & ~r_lock[1];

   // Forward the owner's bus signals to the slave; everything is zero when idle.
   always_comb begin
      s_adr     = '0;
      s_dat_o   = '0;
      s_we      = 1'b0;
      w_own_cyc = 1'b0;
      w_own_stb = 1'b0;
      if (w_own0) begin
         s_adr     = m0_adr;
         s_dat_o   = m0_dat_o;
         s_we      = m0_we;
         w_own_cyc = m0_cyc;
         w_own_stb = m0_stb;
      end else if (w_own1) begin
         s_adr     = m1_adr;
         s_dat_o   = m1_dat_o;
         s_we      = m1_we;
         w_own_cyc = m1_cyc;
         w_own_stb = m1_stb;
      end
   end

   // A coincident slave ack beats the timeout, so ack and err never overlap.
   assign w_timeout = (w_own0 | w_own1) & w_own_cyc & ~s_ack & (r_to_cnt == TO_LIM);
   assign w_release = (w_own0 | w_own1) & (~w_own_cyc | w_timeout);

   // stb is qualified by cyc so a release with stb still high is clean.
   assign s_cyc = w_own_cyc & ~w_timeout;
   assign s_stb = w_own_stb & w_own_cyc & ~w_timeout;

   assign m0_ack   = w_own0 & s_ack;
   assign m1_ack   = w_own1 & s_ack;
   assign m0_err   = w_own0 & w_timeout;
   assign m1_err   = w_own1 & w_timeout;
   assign m0_dat_i = w_own0 ? s_dat_i : 8'h00;
   assign m1_dat_i = w_own1 ? s_dat_i : 8'h00;

   assign owner = r_owner;

   // Grant FSM with round-robin tie break, timeout counter and lockouts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_owner  <= 2'b00;
         r_last   <= 1'b1;
         r_to_cnt <= '0;
         r_lock   <= 2'b00;
      end else begin
         r_lock[0] <= (w_timeout & w_own0) | (r_lock[0] & m0_cyc);
         r_lock[1] <= (w_timeout & w_own1) | (r_lock[1] & m1_cyc);
         case (r_state)
            ST_IDLE: begin
               r_to_cnt <= '0;
               if (w_req0 && (!w_req1 || r_last)) begin
                  r_state <= ST_GNT0;
                  r_owner <= grant_onehot(ST_GNT0);
                  r_last  <= 1'b0;
               end else if (w_req1) begin
                  r_state <= ST_GNT1;
                  r_owner <= grant_onehot(ST_GNT1);
                  r_last  <= 1'b1;
               end
            end
            ST_GNT0: begin
               if (w_release) begin
                  r_to_cnt <= '0;
                  if (w_req1) begin
                     r_state <= ST_GNT1;
                     r_owner <= grant_onehot(ST_GNT1);
                     r_last  <= 1'b1;
                  end else begin
                     r_state <= ST_IDLE;
                     r_owner <= grant_onehot(ST_IDLE);
                  end
               end else if (s_ack) begin
                  r_to_cnt <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            ST_GNT1: begin
               if (w_release) begin
                  r_to_cnt <= '0;
                  if (w_req0) begin
                     r_state <= ST_GNT0;
                     r_owner <= grant_onehot(ST_GNT0);
                     r_last  <= 1'b0;
                  end else begin
                     r_state <= ST_IDLE;
                     r_owner <= grant_onehot(ST_IDLE);
                  end
               end else if (s_ack) begin
                  r_to_cnt <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_owner  <= 2'b00;
               r_to_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_wb_arbiter.sv
// Bench for i2c_wb_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural arbiter model.
module tb_i2c_wb_arbiter;

   localparam int TO = 16;
   localparam int TW = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] cyc, stb, we;
   logic [2:0] adr [2];
   logic [7:0] dwr [2];
   logic [7:0] s_dat_i;
   logic       s_ack;

   logic [7:0] m0_dat_i, m1_dat_i, s_dat_o;
   logic       m0_ack, m1_ack, m0_err, m1_err, s_we, s_stb, s_cyc;
   logic [2:0] s_adr;
   logic [1:0] owner;

   always #5 clk = ~clk;

   i2c_wb_arbiter #(.TIMEOUT(TO), .TO_W(TW)) dut (
      .clk(clk), .rst(rst),
      .m0_adr(adr[0]), .m0_dat_o(dwr[0]), .m0_we(we[0]), .m0_stb(stb[0]), .m0_cyc(cyc[0]),
      .m0_dat_i(m0_dat_i), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_adr(adr[1]), .m1_dat_o(dwr[1]), .m1_we(we[1]), .m1_stb(stb[1]), .m1_cyc(cyc[1]),
      .m1_dat_i(m1_dat_i), .m1_ack(m1_ack), .m1_err(m1_err),
      .s_adr(s_adr), .s_dat_o(s_dat_o), .s_we(s_we), .s_stb(s_stb), .s_cyc(s_cyc),
      .s_dat_i(s_dat_i), .s_ack(s_ack), .owner(owner)
   );

   int total = 0;
   int bad   = 0;
   int cycno = 0;

   // Behavioural model: owner index (-1 none), who was granted last,
   // cycles since grant/ack, and per-requester lockout flags.
   int mo;
   int ml;
   int mc;
   bit lk [2];

   int n_err1 = 0, err1_cyc = -1;
   logic sn_m0_ack, sn_m0_err;

   function automatic void mdl_reset();
      mo = -1; ml = 1; mc = 0; lk[0] = 1'b0; lk[1] = 1'b0;
   endfunction

   function automatic bit mdl_timeout();
      return (mo >= 0) && cyc[mo] && !s_ack && (mc == TO);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycno, obs, exp);
      end
   endtask

   task automatic check_all();
      bit own, eto;
      int o;
      own = (mo >= 0);
      o   = own ? mo : 0;
      eto = mdl_timeout();
      chk("owner",    owner,    own ? (32'd1 << o) : 32'd0);
      chk("s_cyc",    s_cyc,    own && cyc[o] && !eto);
      chk("s_stb",    s_stb,    own && stb[o] && cyc[o] && !eto);
      chk("s_adr",    s_adr,    own ? adr[o] : 3'd0);
      chk("s_dat_o",  s_dat_o,  own ? dwr[o] : 8'd0);
      chk("s_we",     s_we,     own ? we[o] : 1'b0);
      chk("m0_ack",   m0_ack,   own && o == 0 && s_ack);
      chk("m1_ack",   m1_ack,   own && o == 1 && s_ack);
      chk("m0_err",   m0_err,   own && o == 0 && eto);
      chk("m1_err",   m1_err,   own && o == 1 && eto);
      chk("m0_dat_i", m0_dat_i, (own && o == 0) ? s_dat_i : 8'd0);
      chk("m1_dat_i", m1_dat_i, (own && o == 1) ? s_dat_i : 8'd0);
      chk("ack_both", m0_ack & m1_ack, 0);
      if (m1_err) begin n_err1++; err1_cyc = cycno; end
      sn_m0_ack = m0_ack;
      sn_m0_err = m0_err;
   endtask

   function automatic void mdl_advance();
      bit to, r0, r1;
      int y;
      if (!rst) begin
         mdl_reset();
         return;
      end
      to = mdl_timeout();
      r0 = cyc[0] && !lk[0];
      r1 = cyc[1] && !lk[1];
      for (int x = 0; x < 2; x++) begin
         if (to && mo == x) lk[x] = 1'b1;
         else if (!cyc[x]) lk[x] = 1'b0;
      end
      if (mo < 0) begin
         mc = 0;
         if (r0 && r1) mo = 1 - ml;
         else if (r0) mo = 0;
         else if (r1) mo = 1;
         if (mo >= 0) ml = mo;
      end else if (!cyc[mo] || to) begin
         mc = 0;
         y  = 1 - mo;
         if ((y == 0 && r0) || (y == 1 && r1)) begin mo = y; ml = y; end
         else mo = -1;
      end else begin
         mc = s_ack ? 0 : mc + 1;
      end
   endfunction

   // One clock: compare mid-cycle, then advance the model on the edge.
   task automatic step();
      #2;
      check_all();
      @(posedge clk);
      mdl_advance();
      cycno++;
      #1;
   endtask

   task automatic set_m(input int x, input logic c, input logic s, input logic [2:0] a,
                        input logic [7:0] d, input logic w);
      cyc[x] = c; stb[x] = s; adr[x] = a; dwr[x] = d; we[x] = w;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d observed=running expected=finished", cycno);
      $fatal(1, "watchdog");
   end

   initial begin
      int g, ntrans, ncyc;
      rst = 1'b0; s_ack = 1'b0; s_dat_i = 8'h00;
      set_m(0, 0, 0, 0, 0, 0);
      set_m(1, 0, 0, 0, 0, 0);
      mdl_reset();
      step();
      step();
      chk("reset_owner", owner, 0);
      rst = 1'b1;

      // Simultaneous request: m0 first, two writes, then handover to m1.
      set_m(0, 1, 1, 3'd3, 8'h42, 1);
      set_m(1, 1, 1, 3'd1, 8'h55, 1);
      step();
      chk("first_grant", owner, 2'b01);
      s_ack = 1'b1; s_dat_i = 8'hA5;
      step();
      s_ack = 1'b0;
      set_m(0, 1, 1, 3'd4, 8'h90, 1);
      step();
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      set_m(0, 0, 1, 3'd4, 8'h90, 1);
      step();
      chk("handover", owner, 2'b10);
      s_ack = 1'b1; s_dat_i = 8'h3C;
      step();
      s_ack = 1'b0;
      set_m(1, 0, 0, 0, 0, 0);
      step();
      set_m(0, 0, 0, 0, 0, 0);
      step();

      // m0 keeps cyc across five accesses while m1 waits.
      set_m(0, 1, 1, 3'd0, 8'h10, 1);
      set_m(1, 1, 1, 3'd7, 8'hEE, 0);
      step();
      for (int k = 0; k < 5; k++) begin
         adr[0] = 3'(k); dwr[0] = 8'(8'h10 + k);
         s_ack = 1'b0;
         chk("hold_owner", owner, 2'b01);
         step();
         s_ack = 1'b1; s_dat_i = 8'(k * 17);
         step();
      end
      s_ack = 1'b0;
      set_m(0, 0, 0, 0, 0, 0);
      step();
      chk("after_hold", owner, 2'b10);
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      set_m(1, 0, 0, 0, 0, 0);
      step();

      // m1 alone against a slave that never acks: timeout and lockout.
      set_m(1, 1, 1, 3'd2, 8'h77, 1);
      g = -1; n_err1 = 0; err1_cyc = -1;
      for (int i = 0; i < 24; i++) begin
         if (owner == 2'b10 && g < 0) g = cycno;
         step();
      end
      chk("to_once", n_err1, 1);
      chk("to_dist", err1_cyc - g, TO);
      chk("lockout_owner", owner, 0);
      set_m(1, 0, 0, 0, 0, 0);
      step();
      set_m(1, 1, 1, 3'd2, 8'h77, 1);
      step();
      chk("relock_grant", owner, 2'b10);
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      set_m(1, 0, 0, 0, 0, 0);
      step();

      // Ack coinciding with the timeout limit keeps the grant.
      set_m(0, 1, 1, 3'd5, 8'h01, 0);
      step();
      g = cycno;
      chk("to_ack_grant", owner, 2'b01);
      for (int i = 0; i < TO; i++) step();
      s_ack = 1'b1; s_dat_i = 8'hC3;
      step();
      chk("to_ack_ack", sn_m0_ack, 1);
      chk("to_ack_err", sn_m0_err, 0);
      chk("to_ack_keep", owner, 2'b01);
      s_ack = 1'b0;
      step();
      set_m(0, 0, 0, 0, 0, 0);
      step();

      // Asynchronous reset in the middle of an m1 access.
      set_m(1, 1, 1, 3'd6, 8'h99, 1);
      step();
      #2;
      chk("pre_rst_stb", s_stb, 1);
      s_ack = 1'b1;
      rst = 1'b0;
      #1;
      chk("rst_s_cyc", s_cyc, 0);
      chk("rst_s_stb", s_stb, 0);
      chk("rst_owner", owner, 0);
      chk("rst_m1_ack", m1_ack, 0);
      chk("rst_m1_err", m1_err, 0);
      @(posedge clk);
      mdl_advance();
      cycno++;
      #1;
      rst = 1'b1; s_ack = 1'b0;
      set_m(1, 0, 0, 0, 0, 0);
      set_m(0, 1, 1, 3'd1, 8'h11, 1);
      step();
      chk("post_rst_grant", owner, 2'b01);
      set_m(0, 0, 0, 0, 0, 0);
      step();

      // Random traffic until 100 transactions have ended.
      ntrans = 0; ncyc = 0;
      while (ntrans < 100 && ncyc < 5000) begin
         for (int x = 0; x < 2; x++) begin
            if (!cyc[x]) begin
               if ($urandom_range(0, 2) == 0)
                  set_m(x, 1, 1, 3'($urandom), 8'($urandom), 1'($urandom));
            end else if ($urandom_range(0, 4) == 0) begin
               set_m(x, 0, 1'($urandom), adr[x], dwr[x], we[x]);
               ntrans++;
            end else begin
               set_m(x, 1, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom));
            end
         end
         s_ack   = 1'($urandom);
         s_dat_i = 8'($urandom);
         step();
         ncyc++;
      end
      chk("rand_trans", ntrans >= 100, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
